instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Instruction sequencer that sits directly upstream of the simple processor.
//   Walks a program counter through a synchronous-read program ROM and drives the
//   processor's DIN/Run inputs, issuing one instruction at a time and waiting for Done.
//   Supports free-run and single-step modes, a halt opcode, and a Done watchdog.
// PARAMETERS
//   ADDR_W   8    program ROM address width; PC wraps modulo 2**ADDR_W
//   DATA_W   16   instruction width; must equal processor DIN width
//   TIMEOUT  8    max cycles in EXEC without Done before Error (1..255)
// PORTS
//   Clock      in   1       single clock; all state changes on posedge
//   Reset      in   1       synchronous, active-high reset
//   Start      in   1       level; begins/resumes fetching from IDLE
//   Step       in   1       1 = single-step (return to IDLE after each retire)
//   mem_addr   out  ADDR_W  ROM address; combinationally equal to PC
//   mem_q      in   DATA_W  ROM data, valid the cycle after mem_addr is presented
//   DIN        out  DATA_W  instruction word to processor (registered)
//   Run        out  1       one-cycle issue strobe to processor
//   Done       in   1       processor completion, sampled only in EXEC
//   PC         out  ADDR_W  address of current/next instruction
//   InstrCount out  16      retired-instruction count, wraps at 16'hFFFF
//   Halted     out  1       sticky; halt opcode fetched or Error
//   Error      out  1       sticky; Done watchdog expired
// BEHAVIOUR
//   Reset (sync, high): state=IDLE; PC=0, DIN=0, Run=0, InstrCount=0, Halted=0,
//     Error=0, watchdog=0. Reset mid-instruction aborts it; no PC advance, no count.
//   States: IDLE, FETCH, DECODE, ISSUE, EXEC, HALT.
//   IDLE:   Start=1 -> FETCH; else stay. Run=0.
//   FETCH:  mem_addr=PC held 1 cycle (ROM latency) -> DECODE.
//   DECODE: DIN <= mem_q. If mem_q[15:13]==3'b111 (halt opcode) -> HALT, Halted<=1,
//           Run never asserted, PC unchanged. Else -> ISSUE.
//   ISSUE:  Run=1 for exactly this cycle, DIN stable; watchdog<=0 -> EXEC.
//   EXEC:   Run=0, DIN held. Done=1 -> retire: PC<=PC+1 (wrap max->0),
//           InstrCount<=InstrCount+1, next = Step ? IDLE : FETCH.
//           Done=0 -> watchdog+1; when watchdog reaches TIMEOUT-1 with Done=0 ->
//           HALT, Error<=1, Halted<=1, no retire.
//   HALT:   absorbing until Reset; Start/Step/Done ignored; outputs hold.
//   Done outside EXEC ignored (processor is in T0 during ISSUE, Done=0 there).
//   Done and watchdog expiry in same cycle: Done wins (retire, no Error).
//   Step sampled at retire; Start sampled only in IDLE (held-high Start in step
//     mode re-issues next instruction after 1 IDLE cycle).
//   Issue cadence: FETCH->DECODE->ISSUE = 3 cycles overhead + processor cycles;
//     mv/mvt retire 1 cycle after Run, add/sub 3 cycles after Run.
//   mem_addr/PC change only on retire or Reset; DIN changes only in DECODE.
// TESTING
//   1 ROM[0]=mv r0,#5; ROM[1]=halt; Start=1 -> Run pulse once, DIN=16'h1005,
//     PC=1, InstrCount=1, Halted=1, Error=0, second Run never asserted.
//   2 ROM[0]=add r1,#1 (16'h5201) -> Run at cycle 3 after Start, Done 3 cycles
//     later, next FETCH the following cycle; PC=1.
//   3 Step=1, Start pulsed 3 times over 4-instr program -> exactly 3 Run pulses,
//     state IDLE between each, PC=3, InstrCount=3.
//   4 Done tied 0, TIMEOUT=8 -> Error=1, Halted=1 exactly 8 cycles after ISSUE,
//     PC and InstrCount unchanged.
//   5 ADDR_W=2, ROM all mv (no halt), free-run -> PC sequence 0,1,2,3,0,1;
//     InstrCount=6 after six retires.
//   6 Reset asserted in EXEC of add -> next cycle IDLE, Run=0, PC=0, InstrCount=0;
//     Done on that cycle does not retire.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction sequencer for the simple processor. Walks a
//               program counter through a synchronous-read ROM, issues one
//               instruction at a time on DIN/Run and waits for Done before
//               retiring it. Supports free-run and single-step operation, a
//               halt opcode (top three bits all ones) and a Done watchdog.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock      in   1       single clock, all state changes on posedge
//   Reset      in   1       synchronous, active-high reset
//   Start      in   1       level; begins/resumes fetching from IDLE
//   Step       in   1       1 = return to IDLE after each retire
//   mem_addr   out  ADDR_W  ROM address, combinationally equal to PC
//   mem_q      in   DATA_W  ROM data, valid the cycle after mem_addr
//   DIN        out  DATA_W  registered instruction word to the processor
//   Run        out  1       one-cycle issue strobe
//   Done       in   1       processor completion, sampled only in EXEC
//   PC         out  ADDR_W  address of current/next instruction
//   InstrCount out  16      retired-instruction count (wraps)
//   Halted     out  1       sticky; halt opcode fetched or watchdog expired
//   Error      out  1       sticky; Done watchdog expired
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Step,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount,
    output logic              Halted,
    output logic              Error
);

    // Last watchdog value tolerated in EXEC; Done=0 while here expires it.
    localparam logic [7:0]        WD_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0]        HALT_OP = 3'b111;
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  watchdog;

    logic        is_halt_op;
    logic        retire;
    logic        halt_fetch;
    logic        wd_expire;
    logic        load_din;
    logic        wd_clear;
    logic        wd_inc;

    assign is_halt_op = (mem_q[DATA_W-1 -: 3] == HALT_OP);

    // PC is the ROM address directly, so FETCH presents it with no extra cycle.
    assign mem_addr = PC;
    assign Run      = (state == S_ISSUE);

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        halt_fetch = 1'b0;
        wd_expire  = 1'b0;
        load_din   = 1'b0;
        wd_clear   = 1'b0;
        wd_inc     = 1'b0;

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // ROM read latency: data is available in DECODE.
                state_next = S_DECODE;
            end
            S_DECODE: begin
                load_din = 1'b1;
                if (is_halt_op) begin
                    halt_fetch = 1'b1;
                    state_next = S_HALT;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_clear   = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                // Done takes priority over a watchdog expiring in the same cycle.
                if (Done) begin
                    retire     = 1'b1;
                    state_next = Step ? S_IDLE : S_FETCH;
                end else if (watchdog == WD_LAST) begin
                    wd_expire  = 1'b1;
                    state_next = S_HALT;
                end else begin
                    wd_inc     = 1'b1;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            PC         <= '0;
            DIN        <= '0;
            InstrCount <= '0;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            watchdog   <= '0;
        end else begin
            state <= state_next;

            if (load_din) begin
                DIN <= mem_q;
            end

            if (wd_clear) begin
                watchdog <= '0;
            end else if (wd_inc) begin
                watchdog <= watchdog + 8'd1;
            end

            if (retire) begin
                PC         <= PC + PC_ONE;
                InstrCount <= InstrCount + 16'd1;
            end

            if (halt_fetch || wd_expire) begin
                Halted <= 1'b1;
            end

            if (wd_expire) begin
                Error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
